sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that supersedes the fixed 8-bit x 256 buffer. Width, depth, read mode and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, usable capacity of the full DEPTH entries, and sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/sync_fifo_param_mem.sv | 28 ++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Read-mode selectors and the address-width helper used by the FIFO and its RAM.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width for a given depth; never less than one bit.
    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port storage array for the FIFO.
// It has one synchronous write port and one asynchronous read port.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [fifo_addr_w(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [fifo_addr_w(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]             o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width, depth, read mode and thresholds.
// It provides an occupancy count, sticky overflow/underflow and full DEPTH capacity.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr,
    input  logic [DATA_W-1:0]           din,
    input  logic                        rd,
    output logic [DATA_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [fifo_addr_w(DEPTH):0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AEMPTY_TH <= 0) ||
        (AEMPTY_TH >= AFULL_TH) || (AFULL_TH > DEPTH) ||
        ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT))) begin : g_bad_params
        $fatal(1, "sync_fifo_param: illegal parameter set");
    end

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rdata;

    // Handshake: wr/rd are one-cycle requests; a request is accepted at the edge
    // only if !full / !empty beforehand, otherwise it is dropped and flagged sticky.
    assign w_wr_ok = wr && !full;
    assign w_rd_ok = rd && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr && full) begin
                r_overflow <= 1'b1;
            end
            if (rd && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr),
        .i_wdata (din),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout = w_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] r_dout;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout <= '0;
            end else if (w_rd_ok) begin
                r_dout <= w_rdata;
            end
        end

        assign dout = r_dout;
    end

    assign count        = r_count;
    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CNT_W'(AFULL_TH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_TH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read and an FWFT instance, 8 x 16.
// Each scenario task drives its own vectors and checks hand-computed expectations.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_din = 8'h00, s_dout;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [4:0] s_count;

    logic       f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = 8'h00, f_dout;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] f_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr(s_wr), .din(s_din), .rd(s_rd), .dout(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr(f_wr), .din(f_din), .rd(f_rd), .dout(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v[3];
        v = '{8'h11, 8'h22, 8'h33};
        rst = 1'b1; s_wr = 1'b1; s_din = 8'hFF;
        tick(); tick();
        rst = 1'b0; s_wr = 1'b0;
        checks++; if (s_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", s_count); end
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", s_empty); end
        checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", s_full); end
        checks++; if (s_aempty !== 1'b1 || s_afull !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", s_aempty, s_afull); end
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin errors++; $display("FAIL reset_sticky got ovf=%b udf=%b exp 0 0", s_ovf, s_udf); end
        checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 0", s_dout); end
        checks++; if (f_count !== 5'd0 || f_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got cnt=%0d empty=%b exp 0 1", f_count, f_empty); end
        for (int i = 0; i < 3; i++) begin
            s_wr = 1'b1; s_din = v[i];
            tick();
            checks++; if (s_count !== 5'(i + 1)) begin errors++; $display("FAIL basic_wr_count got %0d exp %0d", s_count, i + 1); end
        end
        s_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_rd = 1'b1;
            tick();
            checks++; if (s_dout !== v[i]) begin errors++; $display("FAIL basic_rd_data got %0h exp %0h", s_dout, v[i]); end
            checks++; if (s_count !== 5'(2 - i)) begin errors++; $display("FAIL basic_rd_count got %0d exp %0d", s_count, 2 - i); end
        end
        s_rd = 1'b0;
        tick();
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", s_empty); end
        checks++; if (s_dout !== 8'h33) begin errors++; $display("FAIL basic_dout_hold got %0h exp 33", s_dout); end
    endtask

    task automatic test_fill();
        logic e_af, e_ae;
        for (int i = 0; i < 16; i++) begin
            s_wr = 1'b1; s_din = 8'(i);
            tick();
            e_af = ((i + 1) >= 12);
            e_ae = ((i + 1) <= 4);
            checks++; if (s_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", s_count, i + 1); end
            checks++; if (s_afull !== e_af) begin errors++; $display("FAIL fill_afull at %0d got %b exp %b", i + 1, s_afull, e_af); end
            checks++; if (s_aempty !== e_ae) begin errors++; $display("FAIL fill_aempty at %0d got %b exp %b", i + 1, s_aempty, e_ae); end
        end
        s_wr = 1'b0;
        checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", s_full); end
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", s_ovf); end
        s_wr = 1'b1; s_din = 8'hFF;
        tick();
        s_wr = 1'b0;
        checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b exp 1", s_ovf); end
        checks++; if (s_count !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got %0d exp 16", s_count); end
        for (int i = 0; i < 16; i++) begin
            s_rd = 1'b1;
            tick();
            checks++; if (s_dout !== 8'(i)) begin errors++; $display("FAIL fill_drain_data got %0h exp %0h", s_dout, i); end
        end
        s_rd = 1'b0;
        checks++; if (s_empty !== 1'b1 || s_count !== 5'd0) begin errors++; $display("FAIL fill_drain_empty got empty=%b cnt=%0d exp 1 0", s_empty, s_count); end
        checks++; if (s_ovf !== 1'b1 || s_udf !== 1'b0) begin errors++; $display("FAIL fill_sticky got ovf=%b udf=%b exp 1 0", s_ovf, s_udf); end
    endtask

    task automatic test_wrap();
        logic [7:0] nxt;
        logic [7:0] e;
        nxt = 8'h00;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            if ((c % 3) != 2) begin
                s_wr = 1'b1; s_din = nxt;
                exp_q.push_back(nxt);
                nxt = nxt + 8'd1;
                tick();
                s_wr = 1'b0;
            end else begin
                s_rd = 1'b1;
                e = exp_q.pop_front();
                tick();
                s_rd = 1'b0;
                checks++; if (s_dout !== e) begin errors++; $display("FAIL wrap_data got %0h exp %0h", s_dout, e); end
            end
            checks++; if (s_count !== 5'(exp_q.size())) begin errors++; $display("FAIL wrap_count got %0d exp %0d", s_count, exp_q.size()); end
        end
        while (exp_q.size() > 0) begin
            s_rd = 1'b1;
            e = exp_q.pop_front();
            tick();
            checks++; if (s_dout !== e) begin errors++; $display("FAIL wrap_drain_data got %0h exp %0h", s_dout, e); end
        end
        s_rd = 1'b0;
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", s_empty); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_wr = 1'b1; s_din = 8'h40 + 8'(i);
            tick();
        end
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hEE;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        checks++; if (s_count !== 5'd15) begin errors++; $display("FAIL simul_full_count got %0d exp 15", s_count); end
        checks++; if (s_dout !== 8'h40) begin errors++; $display("FAIL simul_full_data got %0h exp 40", s_dout); end
        checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL simul_full_ovf got %b exp 1", s_ovf); end
        for (int i = 0; i < 15; i++) begin
            s_rd = 1'b1;
            tick();
            checks++; if (s_dout !== 8'h41 + 8'(i)) begin errors++; $display("FAIL simul_full_drain got %0h exp %0h", s_dout, 8'h41 + 8'(i)); end
        end
        s_rd = 1'b0;
        checks++; if (s_empty !== 1'b1 || s_udf !== 1'b0) begin errors++; $display("FAIL simul_drained got empty=%b udf=%b exp 1 0", s_empty, s_udf); end
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h77;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        checks++; if (s_count !== 5'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", s_count); end
        checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL simul_empty_udf got %b exp 1", s_udf); end
        checks++; if (s_dout !== 8'h4F) begin errors++; $display("FAIL simul_empty_hold got %0h exp 4f", s_dout); end
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        checks++; if (s_dout !== 8'h77 || s_empty !== 1'b1) begin errors++; $display("FAIL simul_empty_pop got %0h empty=%b exp 77 1", s_dout, s_empty); end
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            s_wr = 1'b1; s_din = 8'h80 + 8'(i);
            exp_q.push_back(s_din);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h90 + 8'(k);
            e = exp_q.pop_front();
            exp_q.push_back(s_din);
            tick();
            checks++; if (s_count !== 5'd8) begin errors++; $display("FAIL simul_half_count got %0d exp 8", s_count); end
            checks++; if (s_dout !== e) begin errors++; $display("FAIL simul_half_data got %0h exp %0h", s_dout, e); end
        end
        s_wr = 1'b0;
        while (exp_q.size() > 0) begin
            s_rd = 1'b1;
            e = exp_q.pop_front();
            tick();
            checks++; if (s_dout !== e) begin errors++; $display("FAIL simul_half_drain got %0h exp %0h", s_dout, e); end
        end
        s_rd = 1'b0;
    endtask

    task automatic test_fwft();
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_start_empty got %b exp 1", f_empty); end
        f_wr = 1'b1; f_din = 8'hA5;
        tick();
        f_wr = 1'b0;
        checks++; if (f_dout !== 8'hA5) begin errors++; $display("FAIL fwft_show got %0h exp a5", f_dout); end
        checks++; if (f_count !== 5'd1 || f_empty !== 1'b0) begin errors++; $display("FAIL fwft_count got %0d empty=%b exp 1 0", f_count, f_empty); end
        tick();
        checks++; if (f_dout !== 8'hA5) begin errors++; $display("FAIL fwft_hold got %0h exp a5", f_dout); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_count !== 5'd0) begin errors++; $display("FAIL fwft_pop got empty=%b cnt=%0d exp 1 0", f_empty, f_count); end
        checks++; if (f_udf !== 1'b0) begin errors++; $display("FAIL fwft_no_udf got %b exp 0", f_udf); end
        f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h3C;
        tick();
        f_wr = 1'b0; f_rd = 1'b0;
        checks++; if (f_count !== 5'd1 || f_udf !== 1'b1) begin errors++; $display("FAIL fwft_simul_empty got cnt=%0d udf=%b exp 1 1", f_count, f_udf); end
        checks++; if (f_dout !== 8'h3C) begin errors++; $display("FAIL fwft_simul_data got %0h exp 3c", f_dout); end
        f_wr = 1'b1; f_din = 8'h5A;
        tick();
        f_wr = 1'b0;
        checks++; if (f_dout !== 8'h3C) begin errors++; $display("FAIL fwft_head_stable got %0h exp 3c", f_dout); end
        f_rd = 1'b1;
        tick();
        checks++; if (f_dout !== 8'h5A) begin errors++; $display("FAIL fwft_next got %0h exp 5a", f_dout); end
        tick();
        f_rd = 1'b0;
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_final_empty got %b exp 1", f_empty); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) begin
            s_wr = 1'b1; s_din = 8'h50 + 8'(i);
            tick();
        end
        s_wr = 1'b0;
        checks++; if (s_count !== 5'd7) begin errors++; $display("FAIL mid_pre_count got %0d exp 7", s_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (s_count !== 5'd0 || s_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_count got %0d empty=%b exp 0 1", s_count, s_empty); end
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got ovf=%b udf=%b exp 0 0", s_ovf, s_udf); end
        checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL mid_rst_dout got %0h exp 0", s_dout); end
        s_wr = 1'b1; s_din = 8'hC3;
        tick();
        s_wr = 1'b0; s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        checks++; if (s_dout !== 8'hC3) begin errors++; $display("FAIL mid_new_data got %0h exp c3", s_dout); end
        checks++; if (s_empty !== 1'b1 || s_count !== 5'd0) begin errors++; $display("FAIL mid_final got empty=%b cnt=%0d exp 1 0", s_empty, s_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
